// File: rtl/input_conditioner_if.sv
// Pad-side bundle for input_conditioner: raw pad levels in, conditioned
// levels, edge pulses and status strobes out.
interface input_conditioner_if #(
    parameter int NUM_INPUT = 12
);
    logic [NUM_INPUT-1:0] raw_in;
    logic [NUM_INPUT-1:0] clean_out;
    logic [NUM_INPUT-1:0] rise_pulse;
    logic [NUM_INPUT-1:0] fall_pulse;
    logic                 all_high;
    logic                 sample_tick;

    // Producer of raw pad levels / consumer of conditioned outputs.
    modport master (
        output raw_in,
        input  clean_out, rise_pulse, fall_pulse, all_high, sample_tick
    );

    // The conditioner itself.
    modport slave (
        input  raw_in,
        output clean_out, rise_pulse, fall_pulse, all_high, sample_tick
    );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: per-line synchronizer + tick-sampled debouncer.
// A shared prescaler produces sample_tick; each line accepts a new level only
// after DEB_COUNT consecutive disagreeing ticks.
// Optional feature macro: INPUT_COND_EDGE_EN enables rise/fall pulse flops;
// without it rise_pulse/fall_pulse are constant 0.
// Legal parameters: SYNC_STAGES 2..4, PRESCALE >= 1, DEB_COUNT >= 1.

module input_conditioner_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_COUNT   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic tick_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int DW = $clog2(DEB_COUNT) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;

    // Metastability chain; the oldest stage is the synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce decision: only evaluated on sample ticks.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (tick_i) begin
            if (s == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q == DW'(DEB_COUNT - 1)) begin
                clean_d = s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o = clean_q;

`ifdef INPUT_COND_EDGE_EN
    logic rise_q, fall_q;

    // Pulses load on the same edge as the clean level, so they line up with
    // the first cycle showing the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= clean_d & ~clean_q;
            fall_q <= ~clean_d & clean_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif
endmodule

module input_conditioner #(
    parameter int NUM_INPUT   = 12,
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE    = 1000,
    parameter int DEB_COUNT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input_conditioner_if.slave   bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]        pre_q, pre_d;
    logic                 tick_q;
    logic                 all_high_q;
    logic [NUM_INPUT-1:0] clean, rise, fall;

    // Prescaler wraps at PRESCALE-1; with PRESCALE=1 it sits at 0.
    always_comb begin
        pre_d = pre_q + 1'b1;
        if (pre_q == PW'(PRESCALE - 1)) pre_d = '0;
    end

    // Tick is registered off the next count so it is high exactly while the
    // counter holds PRESCALE-1, and stays low through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_d == PW'(PRESCALE - 1));
        end
    end

    input_conditioner_lane #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_COUNT   (DEB_COUNT)
    ) u_lane [NUM_INPUT-1:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (bus.raw_in),
        .tick_i  (tick_q),
        .clean_o (clean),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Status flag, one cycle behind clean_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) all_high_q <= 1'b0;
        else        all_high_q <= &clean;
    end

    assign bus.clean_out   = clean;
    assign bus.rise_pulse  = rise;
    assign bus.fall_pulse  = fall;
    assign bus.all_high    = all_high_q;
    assign bus.sample_tick = tick_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner (NUM_INPUT=12, SYNC_STAGES=2, PRESCALE=4,
// DEB_COUNT=3). Works with or without INPUT_COND_EDGE_EN defined.
module tb_input_conditioner;
    localparam int N = 12;
    localparam int S = 2;
    localparam int P = 4;
    localparam int D = 3;
`ifdef INPUT_COND_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    input_conditioner_if #(.NUM_INPUT(N)) bus ();

    input_conditioner #(
        .NUM_INPUT   (N),
        .SYNC_STAGES (S),
        .PRESCALE    (P),
        .DEB_COUNT   (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw history queue stands in for the synchronizer,
    // edge count modulo P for the prescaler, integer tick counts per line.
    logic [N-1:0] hq[$];
    logic [N-1:0] clean_m, rise_m, fall_m;
    logic         ah_m, tick_m;
    int           dc_m[N];
    int           n_edge;
    int           rise_seen[N], fall_seen[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hq = {};
        repeat (S) hq.push_back('0);
        clean_m = '0; rise_m = '0; fall_m = '0;
        ah_m = 1'b0; tick_m = 1'b0; n_edge = 0;
        for (int i = 0; i < N; i++) dc_m[i] = 0;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < N; i++) begin
            rise_seen[i] = 0;
            fall_seen[i] = 0;
        end
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ".clean"}, 32'(bus.clean_out),   32'(clean_m));
        chk({ph, ".rise"},  32'(bus.rise_pulse),  32'(rise_m));
        chk({ph, ".fall"},  32'(bus.fall_pulse),  32'(fall_m));
        chk({ph, ".allhi"}, 32'(bus.all_high),    32'(ah_m));
        chk({ph, ".tick"},  32'(bus.sample_tick), 32'(tick_m));
    endtask

    // One clock: advance the model across the edge, then compare 1 time unit later.
    task automatic step(input string ph);
        logic [N-1:0] r, s_prev, nc;
        r = bus.raw_in;
        @(posedge clk);
        s_prev = hq[0];
        nc     = clean_m;
        if (tick_m) begin
            for (int i = 0; i < N; i++) begin
                if (s_prev[i] == clean_m[i]) dc_m[i] = 0;
                else if (dc_m[i] == D - 1) begin
                    nc[i]   = s_prev[i];
                    dc_m[i] = 0;
                end else dc_m[i]++;
            end
        end
        rise_m  = EDGE ? (nc & ~clean_m) : '0;
        fall_m  = EDGE ? (~nc & clean_m) : '0;
        ah_m    = &clean_m;
        clean_m = nc;
        hq.push_back(r);
        void'(hq.pop_front());
        n_edge++;
        tick_m = ((n_edge % P) == P - 1);
        #1;
        check_outputs(ph);
        for (int i = 0; i < N; i++) begin
            rise_seen[i] += int'(bus.rise_pulse[i]);
            fall_seen[i] += int'(bus.fall_pulse[i]);
        end
    endtask

    // Assert reset just after an edge, hold it for a few edges checking
    // everything reads zero, then release with raw_in = rel_raw.
    task automatic do_reset(input logic [N-1:0] rel_raw);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outputs("rst_hold");
        end
        bus.raw_in = rel_raw;
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        int cyc;
        bit seen_ah;

        rst_n = 1'b0;
        bus.raw_in = '1;
        model_reset();
        clear_seen();
        #2;
        check_outputs("rst_init");
        @(posedge clk); #1;
        do_reset(12'h001);   // outputs stay 0 while raw_in is all ones

        // Single line held high after release.
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            step("l0");
            if (first == 0 && bus.clean_out[0]) first = k;
        end
        chk("l0_seen", 32'(first != 0), 32'd1);
        chk("l0_lat_max", 32'(first <= S + P * D + 1), 32'd1);
        chk("l0_lat_min", 32'(first >= S + (D - 1) * P + 1), 32'd1);
        chk("l0_rise_cnt", 32'(rise_seen[0]), EDGE ? 32'd1 : 32'd0);
        chk("l0_others", 32'(bus.clean_out), 32'h001);

        // Glitch on line 5 spanning only two ticks.
        clear_seen();
        bus.raw_in = 12'h021;
        repeat (8) step("glitch");
        bus.raw_in = 12'h001;
        repeat (20) step("glitch");
        chk("l5_clean", 32'(bus.clean_out[5]), 32'd0);
        chk("l5_rise", 32'(rise_seen[5]), 32'd0);
        chk("l5_fall", 32'(fall_seen[5]), 32'd0);

        // All lines high, then drop line 11.
        clear_seen();
        bus.raw_in = '1;
        cyc = 0;
        while (bus.clean_out !== 12'hFFF && cyc < 40) begin
            step("allhi");
            cyc++;
        end
        chk("allhi_reached", 32'(bus.clean_out), 32'hFFF);
        chk("allhi_lag0", 32'(bus.all_high), 32'd0);
        step("allhi");
        chk("allhi_lag1", 32'(bus.all_high), 32'd1);
        repeat (3) step("allhi");
        clear_seen();
        bus.raw_in = 12'h7FF;
        cyc = 0;
        while (bus.clean_out[11] !== 1'b0 && cyc < 40) begin
            step("drop11");
            cyc++;
        end
        chk("drop11_clean", 32'(bus.clean_out), 32'h7FF);
        chk("drop11_ah_hold", 32'(bus.all_high), 32'd1);
        step("drop11");
        chk("drop11_ah_low", 32'(bus.all_high), 32'd0);
        chk("drop11_fall_cnt", 32'(fall_seen[11]), EDGE ? 32'd1 : 32'd0);

        // Reset after two disagreeing ticks discards progress.
        do_reset(12'h000);
        bus.raw_in = 12'h008;
        cyc = 0;
        while (dc_m[3] != 2 && cyc < 40) begin
            step("midcnt");
            cyc++;
        end
        chk("midcnt_reached", 32'(dc_m[3]), 32'd2);
        chk("midcnt_clean", 32'(bus.clean_out[3]), 32'd0);
        do_reset(12'h008);
        clear_seen();
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            step("postrst");
            if (first == 0 && bus.clean_out[3]) first = k;
        end
        chk("postrst_lat_min", 32'(first >= S + (D - 1) * P + 1), 32'd1);
        chk("postrst_lat_max", 32'(first != 0 && first <= S + P * D + 1), 32'd1);
        chk("postrst_rise", 32'(rise_seen[3]), EDGE ? 32'd1 : 32'd0);

        // Random traffic: occasional bit flips, some short enough to be rejected.
        seen_ah = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 4) == 0)
                bus.raw_in[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 150) == 0) bus.raw_in = '1;
            step("rand");
            seen_ah |= bus.all_high;
        end
        bus.raw_in = '1;
        repeat (30) step("rand_fill");
        chk("rand_final_allhi", 32'(bus.all_high), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
